// File: rtl/plaintext_icap_loader.sv
// Holds decrypted bitstream words until the GCM tag verifies, then streams them to ICAP.
// Define ICAP_BITSWAP_EN to bit-reverse each byte on icap_data (Xilinx ICAP ordering).
module plaintext_icap_loader #(
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] plaintext,
    input  logic        plaintext_valid,
    input  logic        tag_valid,
    input  logic        complete,
    input  logic        icap_ready,
    output logic [31:0] icap_data,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic        loaded,
    output logic        error,
    output logic [31:0] word_count
);
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [31:0] MAX_WC = 32'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, DONE, REJECT} state_t;

    state_t              state;
    logic [31:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                overflow;
    logic [31:0]         rd_data;
    logic                rd_vld;
    logic [31:0]         sent;

    logic                  new_image;
    logic                  accept;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [31:0]           count_next;
    logic                  ovf_next;
    logic                  out_free;
    logic                  xfer;
    logic                  fifo_empty;

`ifdef ICAP_BITSWAP_EN
    function automatic logic [7:0] rev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    function automatic logic [31:0] present(input logic [31:0] w);
        return {rev8(w[31:24]), rev8(w[23:16]), rev8(w[15:8]), rev8(w[7:0])};
    endfunction
`else
    function automatic logic [31:0] present(input logic [31:0] w);
        return w;
    endfunction
`endif

    always_comb begin
        new_image  = plaintext_valid && (state == IDLE || state == DONE || state == REJECT);
        accept     = plaintext_valid && (state == COLLECT) && (word_count < MAX_WC);
        wr_en      = new_image || accept;
        wr_addr    = new_image ? '0 : wr_ptr[DEPTH_LOG2-1:0];
        count_next = word_count + {31'b0, accept};
        ovf_next   = overflow || (plaintext_valid && (state == COLLECT) && !accept);
        out_free   = icap_csib || icap_ready;
        xfer       = !icap_csib && icap_ready;
        fifo_empty = (rd_ptr == wr_ptr);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= plaintext;
        end
    end

    // Two-stage drain: rd_data is the registered RAM read, icap_data/icap_csib the
    // output stage; each refills whenever the stage ahead of it is free or moving.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            rd_data    <= '0;
            rd_vld     <= 1'b0;
            sent       <= '0;
            icap_data  <= '0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
            loaded     <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            icap_rdwrb <= 1'b0;
            if (new_image) begin
                state      <= COLLECT;
                wr_ptr     <= (DEPTH_LOG2 + 1)'(1);
                rd_ptr     <= '0;
                word_count <= 32'd1;
                overflow   <= 1'b0;
                loaded     <= 1'b0;
                error      <= 1'b0;
                sent       <= '0;
                rd_vld     <= 1'b0;
                icap_csib  <= 1'b1;
            end else begin
                unique case (state)
                    COLLECT: begin
                        if (accept) begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        word_count <= count_next;
                        overflow   <= ovf_next;
                        if (complete) begin
                            if (tag_valid && !ovf_next && count_next != '0) begin
                                state  <= DRAIN;
                                sent   <= '0;
                                rd_vld <= 1'b0;
                            end else begin
                                state  <= REJECT;
                                error  <= 1'b1;
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_free) begin
                            icap_csib <= !rd_vld;
                            icap_data <= present(rd_data);
                        end
                        if (!rd_vld || out_free) begin
                            rd_vld <= !fifo_empty;
                            if (!fifo_empty) begin
                                rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                                rd_ptr  <= rd_ptr + 1'b1;
                            end
                        end
                        if (xfer) begin
                            sent <= sent + 32'd1;
                            if (sent == word_count - 32'd1) begin
                                state     <= DONE;
                                loaded    <= 1'b1;
                                icap_csib <= 1'b1;
                                rd_vld    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_plaintext_icap_loader.sv
// Directed bench for plaintext_icap_loader with a transaction-level model checked every cycle.
module tb_plaintext_icap_loader;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] plaintext;
    logic        plaintext_valid;
    logic        tag_valid;
    logic        complete;
    logic        icap_ready;
    logic [31:0] icap_data;
    logic        icap_csib;
    logic        icap_rdwrb;
    logic        loaded;
    logic        error;
    logic [31:0] word_count;

    int checks = 0;
    int errors = 0;

    plaintext_icap_loader #(.DEPTH_LOG2(3), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .plaintext(plaintext), .plaintext_valid(plaintext_valid),
        .tag_valid(tag_valid), .complete(complete), .icap_ready(icap_ready),
        .icap_data(icap_data), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb),
        .loaded(loaded), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

`ifdef ICAP_BITSWAP_EN
    localparam logic [31:0] GOOD_FIRST = 32'h88888888;
    localparam logic [31:0] GOOD_LAST  = 32'h22222222;
    localparam logic [31:0] SWAP_EXP   = 32'h8040C001;
`else
    localparam logic [31:0] GOOD_FIRST = 32'h11111111;
    localparam logic [31:0] GOOD_LAST  = 32'h44444444;
    localparam logic [31:0] SWAP_EXP   = 32'h01020380;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ICAP_BITSWAP_EN
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
                r[8*b + 7 - k] = w[8*b + k];
`endif
        return r;
    endfunction

    // Model: per-image word list, acceptance rules, and the outcome of the image.
    logic [31:0] pend[$];
    logic [31:0] q[$];
    logic [31:0] xlog[$];
    int          m_count = 0;
    bit          m_err = 0, m_loaded = 0, m_ovf = 0, m_collect = 0, m_drain = 0;
    bit          m_rdwrb = 1, m_rst = 1, hold_v = 0;
    int          age = 0;
    int          n_xfer = 0;
    logic [31:0] hold_d;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("icap_rdwrb", {31'b0, icap_rdwrb}, {31'b0, m_rdwrb});
            chk("word_count", word_count, m_count);
            chk("loaded", {31'b0, loaded}, {31'b0, m_loaded});
            chk("error", {31'b0, error}, {31'b0, m_err});
            if (m_rst) chk("icap_data_reset", icap_data, 32'h0);
            if (!m_drain) begin
                chk("csib_idle", {31'b0, icap_csib}, 32'd1);
            end else begin
                age++;
                if (age < 3) chk("csib_latency", {31'b0, icap_csib}, 32'd1);
                else         chk("csib_stream", {31'b0, icap_csib}, 32'd0);
            end
            if (hold_v) chk("data_hold", icap_data, hold_d);
            hold_v = 0;

            if (reset) begin
                m_count = 0; m_err = 0; m_loaded = 0; m_ovf = 0;
                m_collect = 0; m_drain = 0; m_rdwrb = 1; m_rst = 1;
                q.delete(); pend.delete();
            end else begin
                m_rdwrb = 0; m_rst = 0;
                if (plaintext_valid && !m_collect && !m_drain) begin
                    pend.delete(); pend.push_back(plaintext);
                    m_count = 1; m_err = 0; m_loaded = 0; m_ovf = 0; m_collect = 1;
                    xlog.delete(); n_xfer = 0;
                end else if (m_collect) begin
                    if (plaintext_valid) begin
                        if (m_count < MAXW) begin
                            m_count++;
                            pend.push_back(plaintext);
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    if (complete) begin
                        m_collect = 0;
                        if (tag_valid && !m_ovf && m_count > 0) begin
                            m_drain = 1; age = 0; q = pend;
                        end else begin
                            m_err = 1;
                        end
                    end
                end else if (m_drain && !icap_csib) begin
                    if (icap_ready) begin
                        chk("icap_data", icap_data, exp_word(q[0]));
                        void'(q.pop_front());
                        xlog.push_back(icap_data);
                        n_xfer++;
                        if (q.size() == 0) begin
                            m_drain = 0; m_loaded = 1;
                        end
                    end else begin
                        hold_v = 1; hold_d = icap_data;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        plaintext = w; plaintext_valid = 1'b1;
        step();
        plaintext_valid = 1'b0;
    endtask

    task automatic send_last(input logic [31:0] w, input logic tag);
        plaintext = w; plaintext_valid = 1'b1; complete = 1'b1; tag_valid = tag;
        step();
        plaintext_valid = 1'b0; complete = 1'b0; tag_valid = 1'b0;
    endtask

    task automatic decide(input logic tag);
        complete = 1'b1; tag_valid = tag;
        step();
        complete = 1'b0; tag_valid = 1'b0;
    endtask

    task automatic wait_loaded();
        for (int i = 0; i < 100 && !loaded; i++) step();
    endtask

    initial begin
        logic pat [8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        reset = 1'b1; plaintext = '0; plaintext_valid = 1'b0;
        tag_valid = 1'b0; complete = 1'b0; icap_ready = 1'b0;
        step(); step();
        chk("rst_csib", {31'b0, icap_csib}, 32'd1);
        chk("rst_rdwrb", {31'b0, icap_rdwrb}, 32'd1);
        chk("rst_data", icap_data, 32'h0);
        chk("rst_wc", word_count, 32'd0);
        reset = 1'b0;
        step();

        // good image, ready held high
        icap_ready = 1'b1;
        send_word(32'h11111111); send_word(32'h22222222);
        send_word(32'h33333333); send_word(32'h44444444);
        decide(1'b1);
        wait_loaded();
        chk("good_loaded", {31'b0, loaded}, 32'd1);
        chk("good_error", {31'b0, error}, 32'd0);
        chk("good_wc", word_count, 32'd4);
        chk("good_nxfer", n_xfer, 32'd4);
        chk("good_first", xlog.size() > 0 ? xlog[0] : 32'hx, GOOD_FIRST);
        chk("good_last", xlog.size() > 3 ? xlog[3] : 32'hx, GOOD_LAST);

        // tag failure
        send_word(32'hC0000001); send_word(32'hC0000002); send_word(32'hC0000003);
        decide(1'b0);
        step(); step(); step();
        chk("tagfail_error", {31'b0, error}, 32'd1);
        chk("tagfail_loaded", {31'b0, loaded}, 32'd0);
        chk("tagfail_wc", word_count, 32'd3);

        // backpressure; first word also proves the reject is cleared
        icap_ready = 1'b0;
        send_word(32'hA0000001);
        chk("restart_wc", word_count, 32'd1);
        chk("restart_error", {31'b0, error}, 32'd0);
        send_word(32'hA0000002); send_word(32'hA0000003); send_word(32'hA0000004);
        send_last(32'hA0000005, 1'b1);
        for (int i = 0; i < 10 && icap_csib; i++) step();
        for (int i = 0; i < 8; i++) begin
            icap_ready = pat[i];
            step();
        end
        icap_ready = 1'b1;
        wait_loaded();
        chk("bp_loaded", {31'b0, loaded}, 32'd1);
        chk("bp_nxfer", n_xfer, 32'd5);
        chk("bp_wc", word_count, 32'd5);

        // overflow
        for (int i = 0; i < 9; i++) send_word(32'hB0000000 + i);
        decide(1'b1);
        step(); step(); step();
        chk("ovf_wc", word_count, 32'd8);
        chk("ovf_error", {31'b0, error}, 32'd1);
        chk("ovf_loaded", {31'b0, loaded}, 32'd0);

        // reset during drain after two transfers
        for (int i = 0; i < 6; i++) send_word(32'hD0000000 + i);
        decide(1'b1);
        for (int i = 0; i < 50 && n_xfer < 2; i++) step();
        chk("mid_nxfer", n_xfer, 32'd2);
        reset = 1'b1; icap_ready = 1'b0;
        step();
        chk("mid_csib", {31'b0, icap_csib}, 32'd1);
        chk("mid_rdwrb", {31'b0, icap_rdwrb}, 32'd1);
        chk("mid_loaded", {31'b0, loaded}, 32'd0);
        chk("mid_error", {31'b0, error}, 32'd0);
        chk("mid_wc", word_count, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_rdwrb", {31'b0, icap_rdwrb}, 32'd0);

        // stale complete in IDLE is ignored
        complete = 1'b1; tag_valid = 1'b1;
        step(); step(); step();
        chk("stale_wc", word_count, 32'd0);
        chk("stale_loaded", {31'b0, loaded}, 32'd0);
        complete = 1'b0; tag_valid = 1'b0;
        step();

        // single-word image; presentation order depends on the build
        icap_ready = 1'b1;
        send_word(32'h01020380);
        decide(1'b1);
        wait_loaded();
        chk("swap_loaded", {31'b0, loaded}, 32'd1);
        chk("swap_word", xlog.size() > 0 ? xlog[0] : 32'hx, SWAP_EXP);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
